// File: rtl/commit_loadfill.sv
// Load-miss fill buffer behind commit: fetches missed lines or uncached words
// and serves commit's per-cycle queries until the stalled load hits.
module commit_loadfill #(
   parameter int ENTRIES = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_rdctrl_en,
   input  logic [7:0]  i_rdctrl_fid,
   input  logic [31:0] i_rdctrl_addr,
   input  logic        i_rdctrl_uncached,
   input  logic [1:0]  i_rdctrl_lswidth,
   input  logic [31:0] i_loadbuffer_qaddr,
   output logic        o_loadbuffer_qhit,
   output logic [31:0] o_loadbuffer_qdata,
   input  logic        i_inv_en,
   input  logic [31:0] i_inv_addr,
   input  logic        i_flush,
   output logic        o_mem_rd_req,
   output logic [31:0] o_mem_rd_addr,
   output logic        o_mem_rd_burst,
   output logic [7:0]  o_mem_rd_id,
   input  logic        i_mem_rd_gnt,
   input  logic        i_mem_rd_valid,
   input  logic [31:0] i_mem_rd_data,
   input  logic        i_mem_rd_last,
   output logic        o_busy
);

   localparam int PW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

   typedef enum logic [1:0] {IDLE, REQ, DATA} state_t;

   state_t state, state_nx;

   logic [ENTRIES-1:0] ent_valid;
   logic [27:0]        ent_tag  [ENTRIES];
   logic [3:0][31:0]   ent_data [ENTRIES];
   logic               uc_valid;
   logic [29:0]        uc_addr;
   logic [31:0]        uc_data;
   logic [PW-1:0]      ptr;

   logic               cur_uc;
   logic               stale;
   logic               discard;
   logic [1:0]         beat;
   logic [3:0][31:0]   asm_line;

   logic               c_hit, uc_hit, rd_hit, free;
   logic [31:0]        c_word;
   logic [PW-1:0]      vic;
   logic               accept, inv_cur, fill_done, kill;
   logic [3:0][31:0]   fill_line;
   logic               unused_bits;

   assign unused_bits = ^{i_rdctrl_lswidth, i_rdctrl_addr[1:0],
                          i_loadbuffer_qaddr[1:0], i_inv_addr[1:0]};

   always_comb begin
      c_hit  = 1'b0;
      c_word = '0;
      rd_hit = 1'b0;
      free   = 1'b0;
      vic    = ptr;
      for (int i = 0; i < ENTRIES; i++) begin
         if (ent_valid[i] && ent_tag[i] == i_loadbuffer_qaddr[31:4]) begin
            c_hit  = 1'b1;
            c_word = ent_data[i][i_loadbuffer_qaddr[3:2]];
         end
         if (ent_valid[i] && ent_tag[i] == i_rdctrl_addr[31:4])
            rd_hit = 1'b1;
      end
      // Descending scan so the lowest invalid index wins
      for (int i = ENTRIES - 1; i >= 0; i--) begin
         if (!ent_valid[i]) begin
            free = 1'b1;
            vic  = PW'(i);
         end
      end
      if (i_rdctrl_uncached)
         rd_hit = uc_valid && uc_addr == i_rdctrl_addr[31:2];
   end

   assign uc_hit = uc_valid && uc_addr == i_loadbuffer_qaddr[31:2];
   assign o_loadbuffer_qhit  = uc_hit | c_hit;
   assign o_loadbuffer_qdata = uc_hit ? uc_data : (c_hit ? c_word : '0);

   assign inv_cur = i_inv_en && (cur_uc ?
                    i_inv_addr[31:2] == o_mem_rd_addr[31:2] :
                    i_inv_addr[31:4] == o_mem_rd_addr[31:4]);
   assign fill_done = state == DATA && i_mem_rd_valid && i_mem_rd_last;
   assign kill      = stale | inv_cur;

   always_comb begin
      fill_line       = asm_line;
      fill_line[beat] = i_mem_rd_data;
   end

   always_comb begin
      state_nx = state;
      accept   = 1'b0;
      case (state)
         IDLE: if (i_rdctrl_en && !rd_hit && !i_flush) begin
            accept   = 1'b1;
            state_nx = REQ;
         end
         REQ: begin
            if (i_mem_rd_gnt)  state_nx = DATA;
            else if (i_flush)  state_nx = IDLE;
         end
         DATA: if (i_mem_rd_valid && i_mem_rd_last) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   assign o_busy = state != IDLE;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= IDLE;
         o_mem_rd_req   <= 1'b0;
         o_mem_rd_addr  <= '0;
         o_mem_rd_burst <= 1'b0;
         o_mem_rd_id    <= '0;
         ent_valid      <= '0;
         uc_valid       <= 1'b0;
         uc_addr        <= '0;
         uc_data        <= '0;
         ptr            <= '0;
         cur_uc         <= 1'b0;
         stale          <= 1'b0;
         discard        <= 1'b0;
         beat           <= '0;
         asm_line       <= '0;
         for (int i = 0; i < ENTRIES; i++) begin
            ent_tag[i]  <= '0;
            ent_data[i] <= '0;
         end
      end else begin
         state        <= state_nx;
         o_mem_rd_req <= state_nx == REQ;
         if (accept) begin
            o_mem_rd_addr  <= i_rdctrl_uncached ?
                              {i_rdctrl_addr[31:2], 2'b00} :
                              {i_rdctrl_addr[31:4], 4'b0000};
            o_mem_rd_burst <= !i_rdctrl_uncached;
            o_mem_rd_id    <= i_rdctrl_fid;
            cur_uc         <= i_rdctrl_uncached;
            stale          <= 1'b0;
            discard        <= 1'b0;
            beat           <= '0;
         end
         if (state != IDLE && inv_cur)
            stale <= 1'b1;
         if (state != IDLE && i_flush && cur_uc)
            discard <= 1'b1;
         if (state == DATA && i_mem_rd_valid) begin
            asm_line[beat] <= i_mem_rd_data;
            beat           <= beat + 2'd1;
         end
         if (uc_hit || i_flush ||
             (i_inv_en && uc_addr == i_inv_addr[31:2]))
            uc_valid <= 1'b0;
         for (int i = 0; i < ENTRIES; i++)
            if (i_inv_en && ent_tag[i] == i_inv_addr[31:4])
               ent_valid[i] <= 1'b0;
         // Fill commit last so it overrides clears of an unrelated victim
         if (fill_done && !kill) begin
            if (cur_uc) begin
               if (!discard && !i_flush) begin
                  uc_valid <= 1'b1;
                  uc_addr  <= o_mem_rd_addr[31:2];
                  uc_data  <= i_mem_rd_data;
               end
            end else begin
               ent_valid[vic] <= 1'b1;
               ent_tag[vic]   <= o_mem_rd_addr[31:4];
               ent_data[vic]  <= fill_line;
               if (!free) ptr <= ptr + PW'(1);
            end
         end
      end
   end

endmodule

// File: doc/commit_loadfill.md
# commit_loadfill

Miss-side load path behind commit: takes read requests that commit issues for load misses, fetches the data from memory, and holds it in a small fill buffer that commit queries every cycle until it hits. Cached misses fetch a 16-byte line (4 beats). Uncached (kseg1) misses fetch one word into a single-use slot. Sits between the commit stage and the memory read port; the store buffer invalidates lines through it.

## Interface
- ENTRIES, 4, number of cached line entries (power of two, 2..8)
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- i_rdctrl_en  in  1  read request from commit (re-asserted every cycle while the load stalls)
- i_rdctrl_fid  in  8  fetch id of requesting load
- i_rdctrl_addr  in  32  physical address
- i_rdctrl_uncached  in  1  1 = single-word uncached read
- i_rdctrl_lswidth  in  2  load width (carried, not used for fetch size)
- i_loadbuffer_qaddr  in  32  query address from commit
- o_loadbuffer_qhit  out  1  query hit (combinational)
- o_loadbuffer_qdata  out  32  aligned word at qaddr[31:2] (combinational)
- i_inv_en  in  1  store to address; invalidate line
- i_inv_addr  in  32  store physical address
- i_flush  in  1  pipeline flush
- o_mem_rd_req  out  1  memory read request (registered)
- o_mem_rd_addr  out  32  line-aligned (cached) or word-aligned (uncached) address
- o_mem_rd_burst  out  1  1 = 4-beat burst, 0 = single beat
- o_mem_rd_id  out  8  fid of outstanding request
- i_mem_rd_gnt  in  1  request accepted when req && gnt
- i_mem_rd_valid  in  1  data beat valid
- i_mem_rd_data  in  32  beat data, ascending word order
- i_mem_rd_last  in  1  final beat
- o_busy  out  1  FSM not IDLE

## Operation
- Storage: ENTRIES x {valid, tag[31:4], 4 words}, plus uncached slot {valid, addr[31:2], word}, plus a round-robin pointer.
- FSM states IDLE, REQ, DATA.
- IDLE:
  - Accept i_rdctrl_en only when the address misses. Cached: no valid entry matches the tag and the line is not being filled. Uncached: the slot is not valid with matching addr.
  - Hitting requests are ignored; these are repeats of the same stalled load.
  - On accept: latch addr/fid/uncached, go to REQ.
- REQ: hold o_mem_rd_req until i_mem_rd_gnt, then go to DATA. i_flush in REQ before grant drops the request and returns to IDLE.
- DATA:
  - Each i_mem_rd_valid beat writes the assembly register at a 2-bit beat counter, which then increments.
  - i_mem_rd_last completes the fill, regardless of counter value.
- Fill commit:
  - Cached fills write the lowest-index invalid entry; if none is invalid, the entry at the pointer is replaced and the pointer increments (mod ENTRIES).
  - Uncached fills write the slot.
- Flush during DATA: keep draining beats. A cached line is still written. An uncached result is discarded.
- i_flush clears the uncached slot. Cached entries are kept.
- Invalidation: i_inv_en clears any entry whose tag equals i_inv_addr[31:4] and clears the uncached slot on a word match. If it matches the line in flight, that fill is marked stale and is not written.
- Uncached slot clears the cycle after a query hits it (single use).
- Query:
  - Cached hit returns word qaddr[3:2] of the matching entry.
  - Uncached hit needs qaddr[31:2] equal to the slot addr.
  - If both hit, the uncached slot has priority.
  - On miss, qdata = 0.

## Timing
- Reset values: o_mem_rd_req=0, o_mem_rd_addr=0, o_mem_rd_burst=0, o_mem_rd_id=0, o_busy=0, all valids=0, pointer=0, state IDLE.
- Reset mid-burst: all state clears immediately. Beats arriving afterwards are ignored in IDLE.
- Accept at cycle t: o_mem_rd_req=1 from t+1.
- Grant at cycle g: req=0 and DATA from g+1. Beats may arrive from g+1.
- Last beat at cycle l: entry valid and qhit possible from l+1; IDLE at l+1. A new request is accepted at l+1, so the minimum miss loop is 1 + grant wait + beats + 1.
- Query and invalidate in the same cycle: the query sees pre-invalidation state.
- Simultaneous fill commit and invalidate of the same line: the line ends invalid.
- Queries are purely combinational from registered state; there is no bypass from incoming beats.

## Test plan
- Cached miss at 0x8000_1234, gnt after 2 cycles, beats 11,22,33,44 -> mem addr 0x8000_1230 burst=1; qaddr 0x8000_1234 hits with 0x22 from cycle after last; repeated en ignored.
- Uncached 0xA000_0008, single beat 0xDEAD_BEEF -> burst=0, hit once; qhit=0 the cycle after the hit cycle.
- Fill 5 distinct lines, ENTRIES=4 -> fifth replaces entry 0; the first line's address misses, others hit.
- Store invalidate of the in-flight line during DATA -> after last beat, qhit=0 and a new request is accepted.
- Uncached flush during DATA -> beats drained, slot not written, o_busy low after last. Flush in REQ before gnt -> IDLE next cycle, no beats expected.
- Reset asserted between beat 2 and 3 -> all outputs 0 immediately; later beats produce no hit.
